ex_mdu: RTL and testbench
=========================

// Module: ex_mdu
// PURPOSE
//  Multiply/divide unit in EX; responder to decoder's mduop. Holds HI/LO and executes
//  mult/multu/div/divu/mfhi/mflo/mthi/mtlo; multicycle ops raise stall request to controller.
//  Ops are pre-qualified by decoder flush; EX flush aborts in-flight work. Core is in-order, single-issue.
// PARAMETERS
//  MUL_LAT   2   stall cycles for mult/multu incl. issue cycle (1..4)
//  DIV_BITS  32  quotient bits per divide; one iteration per cycle
// PORTS
//  clk              in   1   clock
//  rst_n            in   1   async active-low reset
//  ex_mduop_i       in   `MDOP_W  one-hot op from ID/EX register
//  ex_opr1_i        in   32  rs value (dividend / multiplicand / mthi,mtlo source)
//  ex_opr2_i        in   32  rt value (divisor / multiplier)
//  ex_flush_i       in   1   flush EX: abort op, no HI/LO write
//  ex_stall_i       in   1   pipeline held by another source
//  ex_mdu_stallreq_o out 1   hold IF..EX; op in progress
//  ex_mdu_rdata_o   out  32  mfhi→HI, mflo→LO, else 0
//  hi_o, lo_o       out  32  architectural HI/LO
// BEHAVIOUR
//  Reset: state IDLE, HI=LO=0, counter=0, stallreq=0, rdata=0.
//  FSM IDLE→{MUL,DIV}→DONE→IDLE. Issue = IDLE & mult/div bit & ~ex_flush_i.
//  Issue cycle: stallreq=1 combinationally; latch operands, signs; load counter.
//  MUL: 33x33 signed product (sign-extend for mult, zero-extend for multu); stallreq=1
//   for MUL_LAT cycles total incl. issue, then DONE.
//  DIV: restoring radix-2 on |opr1|,|opr2| (magnitudes for div); 1 bit/cycle; stallreq=1 in
//   issue + DIV_BITS cycles (33 total), then DONE. Quotient sign = s1^s2; remainder sign = s1.
//  DONE: stallreq=0; if ~ex_stall_i: HI←rem/prod[63:32], LO←quot/prod[31:0] at edge, →IDLE;
//   if ex_stall_i: stay DONE (no re-issue of same instruction).
//  Div by zero: quotient 0xFFFFFFFF, remainder = opr1 (signed fixup still applied); no exception.
//  mthi/mtlo: write HI/LO at edge when IDLE & ~ex_stall_i & ~ex_flush_i; single cycle, no stall.
//  mfhi/mflo: combinational read of registers; prior mthi/mult result visible next cycle (no bypass).
//  ex_flush_i in any state: →IDLE next edge, HI/LO unchanged, stallreq=0 in that cycle.
//  Reset mid-op: immediate IDLE, HI/LO=0. Multiple mduop bits set: illegal, assert in sim.
// CONFIGURATION
//  MDU_DIV_ZERO_FAST_EN defined: opr2==0 at issue → DONE next cycle (1 stall cycle), same result.
//  Undefined: div-by-zero runs full 33 stall cycles.
// STRUCTURE
//  defines.v: `MDOP, `MDOP_W (8), bit indices `MD_MULT,`MD_MULTU,`MD_DIV,`MD_DIVU,
//   `MD_MFHI,`MD_MFLO,`MD_MTHI,`MD_MTLO; FSM state localparams stay local.
//  Sub-module mdu_div_iter: unsigned restoring iteration (remainder/quotient regs, counter, done).
// TESTING
//  mult 0xFFFFFFFD*5 → stall 2 cycles; HI=0xFFFFFFFF LO=0xFFFFFFF1.
//  multu 0xFFFFFFFF*0xFFFFFFFF → HI=0xFFFFFFFE LO=0x00000001.
//  div -7/2 → stall 33 cycles; LO=0xFFFFFFFD HI=0xFFFFFFFF. divu 100/7 → LO=14 HI=2.
//  div in flight, ex_flush_i at iteration 10 → IDLE next cycle, HI/LO keep prior, stallreq=0.
//  div 5/0 → LO=0xFFFFFFFF HI=5; stall 1 cycle with MDU_DIV_ZERO_FAST_EN, else 33.
//  mthi 0x1234 then mfhi → rdata=0x1234; mult finishing with ex_stall_i=1 holds DONE, writes once.

Source files
------------

// File: rtl/ex_mdu_pkg.sv
// Shared widths, mduop bit positions and a sign helper for the EX multiply/divide unit.
package ex_mdu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned MDOP_W = 8;

  // One-hot mduop bit positions driven by the decoder.
  localparam int unsigned MD_MULT  = 0;
  localparam int unsigned MD_MULTU = 1;
  localparam int unsigned MD_DIV   = 2;
  localparam int unsigned MD_DIVU  = 3;
  localparam int unsigned MD_MFHI  = 4;
  localparam int unsigned MD_MFLO  = 5;
  localparam int unsigned MD_MTHI  = 6;
  localparam int unsigned MD_MTLO  = 7;

  // Two's-complement negate when neg is set; used for magnitudes and result fixup.
  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] x, input logic neg);
    return neg ? (~x + DATA_W'(1)) : x;
  endfunction

endpackage

// File: rtl/ex_mdu_div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Starts on i_start with magnitudes; o_last_c marks the cycle whose edge retires the final bit.
module ex_mdu_div_iter
  import ex_mdu_pkg::*;
#(
  parameter int unsigned DIV_BITS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic [DATA_W-1:0] o_quot,
  output logic [DATA_W-1:0] o_rem,
  output logic              o_last_c
);

  localparam int unsigned CNT_W = $clog2(DIV_BITS + 1);

  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_dvs;
  logic [CNT_W-1:0]  r_cnt;

  logic [DATA_W:0]   w_shift;
  logic [DATA_W-1:0] w_diff;
  logic              w_ge;

  // Shift next dividend bit into the partial remainder and trial-subtract the divisor.
  assign w_shift = {r_rem, r_quo[DATA_W-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_diff  = DATA_W'(w_shift - {1'b0, r_dvs});

  assign o_quot   = r_quo;
  assign o_rem    = r_rem;
  assign o_last_c = (r_cnt == CNT_W'(1));

  // Iteration registers; quotient bits shift in where dividend bits shift out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
    end else if (i_abort) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_rem <= '0;
      r_quo <= i_dividend;
      r_dvs <= i_divisor;
      r_cnt <= CNT_W'(DIV_BITS);
    end else if (r_cnt != '0) begin
      r_rem <= w_ge ? w_diff : w_shift[DATA_W-1:0];
      r_quo <= {r_quo[DATA_W-2:0], w_ge};
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit: owns HI/LO, runs mult/div as multicycle ops with a stall
// request, and services mfhi/mflo/mthi/mtlo.
// Optional: define MDU_DIV_ZERO_FAST_EN to finish divide-by-zero one cycle after issue.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int unsigned MUL_LAT  = 2,
  parameter int unsigned DIV_BITS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MDOP_W-1:0] ex_mduop_i,
  input  logic [DATA_W-1:0] ex_opr1_i,
  input  logic [DATA_W-1:0] ex_opr2_i,
  input  logic              ex_flush_i,
  input  logic              ex_stall_i,
  output logic              ex_mdu_stallreq_o,
  output logic [DATA_W-1:0] ex_mdu_rdata_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic [DATA_W-1:0]   r_op1;
  logic [DATA_W-1:0]   r_op2;
  logic                r_sgn;
  logic                r_is_div;
`ifdef MDU_DIV_ZERO_FAST_EN
  logic                r_dz;
`endif

  logic                w_is_mul;
  logic                w_is_div;
  logic                w_issue;
  logic                w_sgn_in;
  logic                w_s1_in;
  logic                w_s2_in;
  logic                w_s1;
  logic                w_s2;
  logic [63:0]         w_a;
  logic [63:0]         w_b;
  logic [63:0]         w_prod;
  logic [DATA_W-1:0]   w_quot;
  logic [DATA_W-1:0]   w_rem;
  logic [DATA_W-1:0]   w_qmag;
  logic [DATA_W-1:0]   w_rmag;
  logic [DATA_W-1:0]   w_res_hi;
  logic [DATA_W-1:0]   w_res_lo;
  logic                w_div_last;

  // Op decode and issue qualification.
  assign w_is_mul = ex_mduop_i[MD_MULT] | ex_mduop_i[MD_MULTU];
  assign w_is_div = ex_mduop_i[MD_DIV]  | ex_mduop_i[MD_DIVU];
  assign w_issue  = (r_state == S_IDLE) & (w_is_mul | w_is_div) & ~ex_flush_i;
  assign w_sgn_in = ex_mduop_i[MD_MULT] | ex_mduop_i[MD_DIV];
  assign w_s1_in  = w_sgn_in & ex_opr1_i[DATA_W-1];
  assign w_s2_in  = w_sgn_in & ex_opr2_i[DATA_W-1];

  // Stall covers the issue cycle and every MUL/DIV cycle; a flush drops it immediately.
  assign ex_mdu_stallreq_o = ~ex_flush_i & (w_issue | (r_state == S_MUL) | (r_state == S_DIV));

  // Latched operand signs (zero for the unsigned variants).
  assign w_s1 = r_sgn & r_op1[DATA_W-1];
  assign w_s2 = r_sgn & r_op2[DATA_W-1];

  // Low 64 bits of the 33x33 product equal a 64x64 product of the extended operands.
  assign w_a    = {{32{w_s1}}, r_op1};
  assign w_b    = {{32{w_s2}}, r_op2};
  assign w_prod = w_a * w_b;

  ex_mdu_div_iter #(
    .DIV_BITS (DIV_BITS)
  ) u_div_iter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (w_issue & w_is_div),
    .i_abort    (ex_flush_i),
    .i_dividend (cond_neg(ex_opr1_i, w_s1_in)),
    .i_divisor  (cond_neg(ex_opr2_i, w_s2_in)),
    .o_quot     (w_quot),
    .o_rem      (w_rem),
    .o_last_c   (w_div_last)
  );

  // Divide magnitudes; the fast divide-by-zero path supplies the same values directly.
`ifdef MDU_DIV_ZERO_FAST_EN
  assign w_qmag = r_dz ? '1 : w_quot;
  assign w_rmag = r_dz ? cond_neg(r_op1, w_s1) : w_rem;
`else
  assign w_qmag = w_quot;
  assign w_rmag = w_rem;
`endif

  // Final HI/LO values with quotient sign s1^s2 and remainder sign s1.
  assign w_res_lo = r_is_div ? cond_neg(w_qmag, w_s1 ^ w_s2) : w_prod[31:0];
  assign w_res_hi = r_is_div ? cond_neg(w_rmag, w_s1)        : w_prod[63:32];

  // Read path sees registered HI/LO only.
  assign ex_mdu_rdata_o = ex_mduop_i[MD_MFHI] ? r_hi :
                          ex_mduop_i[MD_MFLO] ? r_lo : '0;
  assign hi_o = r_hi;
  assign lo_o = r_lo;

  // Control FSM, operand capture and HI/LO update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_sgn    <= 1'b0;
      r_is_div <= 1'b0;
`ifdef MDU_DIV_ZERO_FAST_EN
      r_dz     <= 1'b0;
`endif
    end else if (ex_flush_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_op1    <= ex_opr1_i;
            r_op2    <= ex_opr2_i;
            r_sgn    <= w_sgn_in;
            r_is_div <= w_is_div;
`ifdef MDU_DIV_ZERO_FAST_EN
            r_dz     <= w_is_div & (ex_opr2_i == '0);
`endif
            if (w_is_mul) begin
              if (MUL_LAT <= 1) begin
                r_state <= S_DONE;
              end else begin
                r_state <= S_MUL;
                r_cnt   <= CNT_W'(MUL_LAT - 1);
              end
            end else begin
`ifdef MDU_DIV_ZERO_FAST_EN
              r_state <= (ex_opr2_i == '0) ? S_DONE : S_DIV;
`else
              r_state <= S_DIV;
`endif
            end
          end else if (!ex_stall_i) begin
            if (ex_mduop_i[MD_MTHI]) r_hi <= ex_opr1_i;
            if (ex_mduop_i[MD_MTLO]) r_lo <= ex_opr1_i;
          end
        end
        S_MUL: begin
          if (r_cnt <= CNT_W'(1)) begin
            r_state <= S_DONE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DIV: begin
          if (w_div_last) r_state <= S_DONE;
        end
        S_DONE: begin
          if (!ex_stall_i) begin
            r_hi    <= w_res_hi;
            r_lo    <= w_res_lo;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The decoder never sends more than one mduop bit at once.
  a_mduop_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ex_mduop_i))
    else $error("ex_mdu: multiple mduop bits set: %b", ex_mduop_i);

endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu: table of mult/div vectors plus hand sequences for
// mthi/mfhi, flush mid-divide, held DONE, gated moves and reset mid-op.
module tb_ex_mdu;

  localparam logic [7:0] OP_NONE  = 8'h00;
  localparam logic [7:0] OP_MULT  = 8'h01;
  localparam logic [7:0] OP_MULTU = 8'h02;
  localparam logic [7:0] OP_DIV   = 8'h04;
  localparam logic [7:0] OP_DIVU  = 8'h08;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MFLO  = 8'h20;
  localparam logic [7:0] OP_MTHI  = 8'h40;
  localparam logic [7:0] OP_MTLO  = 8'h80;

`ifdef MDU_DIV_ZERO_FAST_EN
  localparam int DZ_STALL = 1;
`else
  localparam int DZ_STALL = 33;
`endif

  logic        clk;
  logic        rst_n;
  logic [7:0]  mduop;
  logic [31:0] opr1;
  logic [31:0] opr2;
  logic        flush;
  logic        exstall;
  logic        stallreq;
  logic [31:0] rdata;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stl;
  } vec_t;

  vec_t vt[10];

  ex_mdu #(
    .MUL_LAT  (2),
    .DIV_BITS (32)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ex_mduop_i        (mduop),
    .ex_opr1_i         (opr1),
    .ex_opr2_i         (opr2),
    .ex_flush_i        (flush),
    .ex_stall_i        (exstall),
    .ex_mdu_stallreq_o (stallreq),
    .ex_mdu_rdata_o    (rdata),
    .hi_o              (hi),
    .lo_o              (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue an op, count stall cycles, let the DONE edge pass, then drop the op.
  task automatic do_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int n);
    n = 0;
    @(negedge clk);
    mduop = op; opr1 = a; opr2 = b;
    #1;
    while (stallreq === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    mduop = OP_NONE; opr1 = '0; opr2 = '0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    vt[0] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 2};
    vt[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2};
    vt[2] = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vt[3] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33};
    vt[4] = '{OP_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, DZ_STALL};
    vt[5] = '{OP_MULT,  32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 2};
    vt[6] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vt[7] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 33};
    vt[8] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
    vt[9] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 2};

    rst_n = 1'b0; mduop = OP_NONE; opr1 = '0; opr2 = '0; flush = 1'b0; exstall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_stallreq", 32'(stallreq), 32'h0);
    chk("reset_rdata", rdata, 32'h0);

    for (int i = 0; i < 10; i++) begin
      do_op(vt[i].op, vt[i].a, vt[i].b, n);
      chk($sformatf("vec%0d_stall_cycles", i), 32'(n), 32'(vt[i].stl));
      chk($sformatf("vec%0d_hi", i), hi, vt[i].hi);
      chk($sformatf("vec%0d_lo", i), lo, vt[i].lo);
    end

    // mthi/mtlo are single-cycle and readable one cycle later
    @(negedge clk); mduop = OP_MTHI; opr1 = 32'h00001234; #1;
    chk("mthi_no_stall", 32'(stallreq), 32'h0);
    @(negedge clk); mduop = OP_MTLO; opr1 = 32'h0000ABCD; #1;
    @(negedge clk); mduop = OP_MFHI; opr1 = '0; #1;
    chk("mfhi_rdata", rdata, 32'h00001234);
    @(negedge clk); mduop = OP_MFLO; #1;
    chk("mflo_rdata", rdata, 32'h0000ABCD);
    @(negedge clk); mduop = OP_NONE; #1;
    chk("idle_rdata_zero", rdata, 32'h0);

    // flush a divide at iteration 10
    @(negedge clk); mduop = OP_DIVU; opr1 = 32'd100; opr2 = 32'd7;
    repeat (10) @(negedge clk);
    #1;
    chk("div_busy_stall", 32'(stallreq), 32'h1);
    flush = 1'b1; #1;
    chk("flush_cycle_stall", 32'(stallreq), 32'h0);
    @(negedge clk); flush = 1'b0; mduop = OP_NONE; opr1 = '0; opr2 = '0; #1;
    chk("after_flush_stall", 32'(stallreq), 32'h0);
    chk("after_flush_hi", hi, 32'h00001234);
    chk("after_flush_lo", lo, 32'h0000ABCD);
    repeat (40) @(negedge clk);
    #1;
    chk("late_flush_hi", hi, 32'h00001234);
    chk("late_flush_lo", lo, 32'h0000ABCD);

    // mult reaching DONE while the pipeline is held elsewhere
    @(negedge clk); mduop = OP_MULT; opr1 = 32'd3; opr2 = 32'd4; #1;
    chk("hold_issue_stall", 32'(stallreq), 32'h1);
    @(negedge clk); #1;
    chk("hold_mul_stall", 32'(stallreq), 32'h1);
    @(negedge clk); #1;
    chk("hold_done_stall", 32'(stallreq), 32'h0);
    exstall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk($sformatf("held_done%0d_stall", k), 32'(stallreq), 32'h0);
      chk($sformatf("held_done%0d_lo", k), lo, 32'h0000ABCD);
    end
    exstall = 1'b0;
    @(negedge clk); mduop = OP_NONE; opr1 = '0; opr2 = '0; #1;
    chk("held_write_hi", hi, 32'h0);
    chk("held_write_lo", lo, 32'd12);
    chk("held_no_reissue", 32'(stallreq), 32'h0);

    // moves are suppressed by stall and by flush
    @(negedge clk); mduop = OP_MTLO; opr1 = 32'h0000DEAD; exstall = 1'b1;
    @(negedge clk); mduop = OP_MTLO; opr1 = 32'h0000BEEF; exstall = 1'b0; flush = 1'b1;
    @(negedge clk); mduop = OP_NONE; opr1 = '0; flush = 1'b0; #1;
    chk("gated_mtlo_lo", lo, 32'd12);

    // reset mid-divide clears HI/LO and returns to idle
    @(negedge clk); mduop = OP_MTHI; opr1 = 32'h00C0FFEE;
    @(negedge clk); mduop = OP_DIVU; opr1 = 32'd100; opr2 = 32'd7;
    repeat (5) @(negedge clk);
    #2; rst_n = 1'b0; mduop = OP_NONE; opr1 = '0; opr2 = '0; #1;
    chk("midop_reset_hi", hi, 32'h0);
    chk("midop_reset_lo", lo, 32'h0);
    chk("midop_reset_stall", 32'(stallreq), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    chk("post_reset_stall", 32'(stallreq), 32'h0);
    chk("post_reset_hi", hi, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
